// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared scan states, blanking constants and hex segment table
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AC_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble
    function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational nibble to active-low 7-segment decoder
module hex_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_seg(nibble);

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit multiplexed 7-segment scanner with guard gaps
// and frame-aligned data commit.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 500,
    parameter int CNT_W       = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        LOAD,
    input  logic [15:0] DATA_IN,
    input  logic [3:0]  DP_IN,
    input  logic        BLANK_EN,
    output logic [3:0]  AC,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        SEL7SEG,
    output logic        PENDING,
    output logic        FRAME_DONE
);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);

    scan_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic             frame_end;

    logic [15:0] act_data, sh_data;
    logic [3:0]  act_dp, sh_dp;

    logic [3:0]  nibble_nxt;
    logic [6:0]  seg_dec;
    logic [3:1]  lead_nz;
    logic        blank_sel;

    logic [3:0]  ac_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        if (!EN) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_GUARD;
                    cnt_nxt   = '0;
                    idx_nxt   = 2'd0;
                end
                ST_GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        state_nxt = ST_DRIVE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        state_nxt = ST_GUARD;
                        cnt_nxt   = '0;
                        idx_nxt   = idx + 2'd1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = 2'd0;
                end
            endcase
        end
    end

    assign frame_end = EN && (state == ST_DRIVE) && (cnt == DRIVE_LAST) && (idx == 2'd3);

    // lead_nz[i]: nibble i or any higher nibble is non-zero
    assign lead_nz[3] = (act_data[15:12] != 4'h0);
    assign lead_nz[2] = lead_nz[3] || (act_data[11:8] != 4'h0);
    assign lead_nz[1] = lead_nz[2] || (act_data[7:4] != 4'h0);
    assign blank_sel  = BLANK_EN && (idx_nxt != 2'd0) && !lead_nz[idx_nxt];

    assign nibble_nxt = act_data[{idx_nxt, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .nibble (nibble_nxt),
        .seg    (seg_dec)
    );

    // Outputs are computed for the state being entered so they line up with it
    always_comb begin
        ac_nxt  = AC_OFF;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (state_nxt == ST_DRIVE && !blank_sel) begin
            ac_nxt  = ~(4'b0001 << idx_nxt);
            seg_nxt = seg_dec;
            dp_nxt  = ~act_dp[idx_nxt];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AC         <= AC_OFF;
            SEG        <= SEG_OFF;
            DP         <= 1'b1;
            SEL7SEG    <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            AC         <= ac_nxt;
            SEG        <= seg_nxt;
            DP         <= dp_nxt;
            SEL7SEG    <= (state_nxt != ST_IDLE);
            FRAME_DONE <= frame_end;
        end
    end

    // Shadow commits to active only at a frame end so a frame never mixes words
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            act_data <= 16'h0000;
            act_dp   <= 4'h0;
            sh_data  <= 16'h0000;
            sh_dp    <= 4'h0;
            PENDING  <= 1'b0;
        end else if (LOAD && state == ST_IDLE) begin
            act_data <= DATA_IN;
            act_dp   <= DP_IN;
            sh_data  <= DATA_IN;
            sh_dp    <= DP_IN;
        end else begin
            if (frame_end && PENDING) begin
                act_data <= sh_data;
                act_dp   <= sh_dp;
            end
            if (LOAD) begin
                sh_data <= DATA_IN;
                sh_dp   <= DP_IN;
                PENDING <= 1'b1;
            end else if (frame_end) begin
                PENDING <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl against a
// frame-position reference model.
module tb_display_scan_ctrl;

    localparam int RD    = 4;
    localparam int GC    = 1;
    localparam int SLOT  = RD + GC;
    localparam int FRAME = 4 * SLOT;

    logic        CLK = 1'b0;
    logic        RST, EN, LOAD, BLANK_EN;
    logic [15:0] DATA_IN;
    logic [3:0]  DP_IN;
    logic [3:0]  AC;
    logic [6:0]  SEG;
    logic        DP, SEL7SEG, PENDING, FRAME_DONE;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Reference model: time since scan start, plus data words
    bit        m_run;
    int        m_t;
    bit        m_fd;
    bit        m_blk;
    bit        m_pend;
    bit [15:0] m_act, m_sh;
    bit [3:0]  m_actdp, m_shdp;

    display_scan_ctrl #(.REFRESH_DIV(RD), .GUARD_CYC(GC), .CNT_W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .LOAD       (LOAD),
        .DATA_IN    (DATA_IN),
        .DP_IN      (DP_IN),
        .BLANK_EN   (BLANK_EN),
        .AC         (AC),
        .SEG        (SEG),
        .DP         (DP),
        .SEL7SEG    (SEL7SEG),
        .PENDING    (PENDING),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    function automatic bit [6:0] ref_seg(input bit [3:0] n);
        bit [6:0] lit;
        case (n)
            4'h0: lit = 7'h40; 4'h1: lit = 7'h79; 4'h2: lit = 7'h24; 4'h3: lit = 7'h30;
            4'h4: lit = 7'h19; 4'h5: lit = 7'h12; 4'h6: lit = 7'h02; 4'h7: lit = 7'h78;
            4'h8: lit = 7'h00; 4'h9: lit = 7'h10; 4'hA: lit = 7'h08; 4'hB: lit = 7'h03;
            4'hC: lit = 7'h46; 4'hD: lit = 7'h21; 4'hE: lit = 7'h06; default: lit = 7'h0E;
        endcase
        return lit;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0; m_fd = 0; m_blk = 0; m_pend = 0;
        m_act = 0; m_sh = 0; m_actdp = 0; m_shdp = 0;
    endtask

    task automatic model_edge();
        bit run_b;
        bit commit;
        if (RST) begin
            model_reset();
        end else begin
            run_b  = m_run;
            commit = 0;
            m_blk  = BLANK_EN;
            if (!EN) begin
                m_run = 0; m_t = 0;
            end else if (!run_b) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t++;
                commit = (m_t % FRAME == 0);
            end
            m_fd = commit;
            if (commit && m_pend) begin
                m_act = m_sh; m_actdp = m_shdp; m_pend = 0;
            end else if (commit) begin
                m_pend = 0;
            end
            if (LOAD) begin
                if (!run_b) begin
                    m_act = DATA_IN; m_actdp = DP_IN; m_sh = DATA_IN; m_shdp = DP_IN;
                end else begin
                    m_sh = DATA_IN; m_shdp = DP_IN; m_pend = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit [3:0] e_ac  = 4'hF;
        bit [6:0] e_seg = 7'h7F;
        bit       e_dp  = 1'b1;
        int pos, d;
        if (m_run) begin
            pos = m_t % FRAME;
            d   = pos / SLOT;
            if (pos % SLOT >= GC && !(m_blk && d > 0 && (m_act >> (4 * d)) == 0)) begin
                e_ac  = ~(4'b0001 << d);
                e_seg = ref_seg(4'((m_act >> (4 * d)) & 16'hF));
                e_dp  = ~m_actdp[d];
            end
        end
        check("AC", AC, e_ac);
        check("SEG", SEG, e_seg);
        check("DP", DP, e_dp);
        check("SEL7SEG", SEL7SEG, m_run);
        check("PENDING", PENDING, m_pend);
        check("FRAME_DONE", FRAME_DONE, m_fd);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p);
        LOAD = 1'b1; DATA_IN = d; DP_IN = p;
        tick();
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; LOAD = 1'b0; BLANK_EN = 1'b0; DATA_IN = 16'h0; DP_IN = 4'h0;
        model_reset();
        repeat (2) tick();
        RST = 1'b0;
        tick();

        // Load in IDLE, then scan one full frame
        load_word(16'h1234, 4'h0);
        EN = 1'b1;
        tick();
        check("t2_guard_ac", AC, 4'hF);
        tick();
        check("t2_d0_ac", AC, 4'b1110);
        check("t2_d0_seg", SEG, 7'h19);
        repeat (FRAME) tick();

        // Asynchronous reset while a digit is driven
        repeat (2) tick();
        RST = 1'b1;
        #1;
        check("t1_async_ac", AC, 4'hF);
        check("t1_async_seg", SEG, 7'h7F);
        check("t1_async_sel", SEL7SEG, 1'b0);
        model_reset();
        EN = 1'b0;
        tick();
        RST = 1'b0;

        // Mid-frame load waits for the frame boundary
        load_word(16'h1234, 4'h0);
        EN = 1'b1;
        repeat (7) tick();
        load_word(16'hABCD, 4'h0);
        check("t3_pending", PENDING, 1'b1);
        for (int i = 0; i < 2 * FRAME && !FRAME_DONE; i++) tick();
        check("t3_frame_done", FRAME_DONE, 1'b1);
        check("t3_pending_clr", PENDING, 1'b0);
        tick();
        check("t3_d0_seg", SEG, 7'h21);

        // Leading-zero blanking
        EN = 1'b0;
        tick();
        BLANK_EN = 1'b1;
        load_word(16'h0050, 4'hF);
        EN = 1'b1;
        repeat (7) tick();
        check("t4_d1_ac", AC, 4'b1101);
        check("t4_d1_seg", SEG, 7'h12);
        repeat (5) tick();
        check("t4_d2_blank", AC, 4'hF);
        EN = 1'b0;
        tick();
        load_word(16'h0000, 4'h0);
        EN = 1'b1;
        repeat (FRAME + 2) tick();

        // EN drop during digit2 drive, then restart
        EN = 1'b0;
        tick();
        BLANK_EN = 1'b0;
        load_word(16'h1234, 4'h0);
        EN = 1'b1;
        repeat (12) tick();
        EN = 1'b0;
        tick();
        check("t5_idle_ac", AC, 4'hF);
        check("t5_idle_sel", SEL7SEG, 1'b0);
        EN = 1'b1;
        tick();
        tick();
        check("t5_restart_ac", AC, 4'b1110);

        // Load landing on the commit edge
        load_word(16'h5678, 4'h0);
        for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) tick();
        load_word(16'h9ABC, 4'h0);
        check("t6_frame_done", FRAME_DONE, 1'b1);
        check("t6_pending", PENDING, 1'b1);
        tick();
        check("t6_d0_seg", SEG, 7'h00);
        for (int i = 0; i < 2 * FRAME && !FRAME_DONE; i++) tick();
        check("t6_pending_clr", PENDING, 1'b0);
        tick();
        check("t6_newer_seg", SEG, 7'h46);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (EN && $urandom_range(59) == 0) EN = 1'b0;
            else if (!EN && $urandom_range(3) == 0) EN = 1'b1;
            if ($urandom_range(199) == 0) BLANK_EN = ~BLANK_EN;
            if ($urandom_range(24) == 0) begin
                LOAD    = 1'b1;
                DATA_IN = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(3)));
                DP_IN   = 4'($urandom);
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
